// File: rtl/mdu_ctrl_if.sv
// EX <-> multiply/divide unit bundle: operation request in, busy/done status and HI/LO out.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, A, B, input busy, done, hi, lo);
  modport slave  (input start, md_op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV controller for EX. The result is computed at issue and parked in phi/plo.
// A latency counter then models the multi-cycle delay before the result commits to HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] phi, plo, hi_q, lo_q;
  logic        pwr, done_q;

  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic        [31:0] dvs;
  logic signed [31:0] sq, sr;
  logic        [31:0] uq, ur;
  logic        [63:0] res;
  logic               res_wr;

  assign smul = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign umul = {32'd0, bus.A} * {32'd0, bus.B};

  // A zero divisor is swapped for 1 so the dividers never produce X; the result is then discarded.
  assign dvs = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign sq  = $signed(bus.A) / $signed(dvs);
  assign sr  = $signed(bus.A) % $signed(dvs);
  assign uq  = bus.A / dvs;
  assign ur  = bus.A % dvs;

  always_comb begin
    res    = 64'd0;
    res_wr = 1'b1;
    case (bus.md_op)
      OP_MULT:  res = smul;
      OP_MULTU: res = umul;
      OP_DIV: begin
        if (bus.B == 32'd0)
          res_wr = 1'b0;
        else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {sr, sq};
      end
      OP_DIVU: begin
        if (bus.B == 32'd0) res_wr = 1'b0;
        else                res = {ur, uq};
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      phi    <= 32'd0;
      plo    <= 32'd0;
      pwr    <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          case (bus.md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              {phi, plo} <= res;
              pwr        <= res_wr;
              cnt        <= (bus.md_op == OP_MULT || bus.md_op == OP_MULTU) ? MC : DC;
              state      <= RUN;
            end
            OP_MTHI: hi_q <= bus.A;
            OP_MTLO: lo_q <= bus.A;
            default: ;
          endcase
        end
      end else begin
        // start is deliberately ignored here, MTHI/MTLO included.
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          state  <= IDLE;
          done_q <= 1'b1;
          if (pwr) begin
            hi_q <= phi;
            lo_q <= plo;
          end
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of mult/div vectors plus hand-written reset/hazard sequences.
module tb_mdu_ctrl;
  logic clk, reset;
  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          n;
    string       nm;
  } vec_t;

  vec_t        vt[8];
  int          tests = 0, fails = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the negedge of the first cycle after issue; follows the op through commit.
  task automatic wait_result(input int n, input logic [31:0] ehi, input logic [31:0] elo,
                             input string nm);
    int  c = 0;
    bit  stable = 1'b1;
    while (bus.busy && c < 40) begin
      c++;
      if (bus.hi !== mhi || bus.lo !== mlo || bus.done !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, 32'(c), 32'(n));
    chk({nm, " hi/lo held while busy"}, 32'(stable), 32'd1);
    chk({nm, " done"}, {31'd0, bus.done}, 32'd1);
    chk({nm, " hi"}, bus.hi, ehi);
    chk({nm, " lo"}, bus.lo, elo);
    mhi = ehi;
    mlo = elo;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm);
    issue(op, a, b);
    wait_result(n, ehi, elo, nm);
    @(negedge clk);
    chk({nm, " done single pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 5,  "mult neg"};
    vt[1] = '{4'd1, 32'hFFFF_FFFD, 32'd5,          32'h0000_0004, 32'hFFFF_FFF1, 5,  "multu"};
    vt[2] = '{4'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div neg dividend"};
    vt[3] = '{4'd3, 32'd7,         32'd2,          32'd1,         32'd3,         10, "divu"};
    vt[4] = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 10, "div overflow"};
    vt[5] = '{4'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 5,  "mult max pos"};
    vt[6] = '{4'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 10, "div neg divisor"};
    vt[7] = '{4'd3, 32'hFFFF_FFFF, 32'd16,         32'd15,        32'h0FFF_FFFF, 10, "divu big"};

    reset = 1'b1; bus.start = 1'b0; bus.md_op = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].n, vt[i].ehi, vt[i].elo, vt[i].nm);

    // md_op outside the defined range must be inert
    issue(4'd7, 32'hAAAA_AAAA, 32'd3);
    chk("noop busy", {31'd0, bus.busy}, 32'd0);
    chk("noop hi", bus.hi, mhi);
    chk("noop lo", bus.lo, mlo);

    issue(4'd4, 32'h1234_5678, 32'd0);
    chk("mthi hi", bus.hi, 32'h1234_5678);
    chk("mthi busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi done", {31'd0, bus.done}, 32'd0);
    chk("mthi lo kept", bus.lo, mlo);
    mhi = 32'h1234_5678;
    issue(4'd5, 32'h0BAD_F00D, 32'd0);
    chk("mtlo lo", bus.lo, 32'h0BAD_F00D);
    chk("mtlo hi kept", bus.hi, mhi);
    mlo = 32'h0BAD_F00D;

    run_op(4'd2, 32'd9, 32'd0, 10, mhi, mlo, "div by zero");
    run_op(4'd3, 32'd9, 32'd0, 10, mhi, mlo, "divu by zero");

    // asynchronous reset in the middle of a multiply
    issue(4'd0, 32'd6, 32'd7);
    @(negedge clk); @(negedge clk);
    chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", {31'd0, bus.busy}, 32'd0);
    chk("async reset hi", bus.hi, 32'd0);
    chk("async reset lo", bus.lo, 32'd0);
    #1 reset = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    begin
      bit quiet = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
          quiet = 1'b0;
      end
      chk("no commit after reset", 32'(quiet), 32'd1);
    end
    run_op(4'd1, 32'h0001_0000, 32'h0003_0000, 5, 32'd3, 32'd0, "multu after reset");

    // start during busy is ignored; start on the done cycle is accepted
    mhi = 32'd0; mlo = 32'd0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    issue(4'd0, 32'd3, 32'd4);
    issue(4'd5, 32'hDEAD_BEEF, 32'd0);
    chk("mtlo while busy", bus.lo, 32'd0);
    begin
      int k = 0;
      while (bus.done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    end
    chk("b2b first done", {31'd0, bus.done}, 32'd1);
    chk("b2b first lo", bus.lo, 32'd12);
    chk("b2b first hi", bus.hi, 32'd0);
    mhi = 32'd0; mlo = 32'd12;
    issue(4'd3, 32'd100, 32'd7);
    chk("b2b busy next cycle", {31'd0, bus.busy}, 32'd1);
    wait_result(10, 32'd2, 32'd14, "b2b divu");

    // MTHI on the done cycle overwrites the just-committed HI
    issue(4'd0, 32'd2, 32'd2);
    begin
      int k = 0;
      while (bus.done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    end
    chk("mthi-on-done lo", bus.lo, 32'd4);
    issue(4'd4, 32'hCAFE_0001, 32'd0);
    chk("mthi-on-done hi", bus.hi, 32'hCAFE_0001);
    chk("mthi-on-done busy", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the P6 pipeline, sitting beside the ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and models the fixed multi-cycle latency with a busy/done handshake.
- Owns the architectural HI/LO registers.
- The hazard unit stalls MD-class instructions in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  EX holds a valid MD-class instruction this cycle.
- md_op  input  4  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..15=no-op.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  a multiply/divide is in progress.
- done  output  1  one-cycle pulse; HI/LO have just been updated by a mult/div.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- One clock domain: clk.
- Reset is asynchronous, active-high, named reset.
- On reset assertion, at any time including mid-operation:
  - busy=0, done=0, hi=0, lo=0.
  - State returns to IDLE; counter and pending result clear to 0.
  - The aborted operation never commits.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, with a 4-bit down-counter cnt.
- IDLE with start=1 at edge ending cycle t:
  - MULT/MULTU/DIV/DIVU:
    - Compute the result from A and B sampled at that edge; store it in pending {phi,plo}.
    - Set cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
    - busy is high for cycles t+1 .. t+N (N = latency).
  - MTHI: hi<=A; MTLO: lo<=A.
    - Visible in cycle t+1.
    - No busy, no done.
    - The other register is unchanged.
  - md_op 6..15: no effect.
- RUN:
  - Each edge decrements cnt.
  - At the edge ending cycle t+N (cnt==1): hi<=phi, lo<=plo, return to IDLE.
  - busy=0 and done=1 in cycle t+N+1 only; new HI/LO are visible in the same cycle.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = bits 63:32, lo = bits 31:0.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Division by zero (B==0, DIV or DIVU):
  - Runs the full DIV_CYCLES with busy.
  - done pulses.
  - hi and lo keep their previous values; no X is ever driven.
- start=1 while busy=1:
  - Ignored entirely, including MTHI/MTLO.
  - The hazard unit guarantees this does not happen; the block must still stay robust to it.
- start on the cycle done=1 (state already IDLE): accepted normally.
  - A back-to-back op starts busy in the very next cycle.
  - MTHI/MTLO in that cycle overwrite the just-committed value.
- Pending registers are internal; hi/lo change only on commit, MTHI/MTLO, or reset.
- No combinational path from any input to any output.
  - Every output is a flop or a decode of state.

Test Plan:
- Reset then MULT A=0xFFFFFFFD B=5, start in cycle 0:
  - busy=1 in cycles 1..5.
  - Cycle 6: done=1, busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - hi/lo unchanged (0) during cycles 1..5.
- MULTU with the same operands: hi=0x00000004, lo=0xFFFFFFF1 after 5 busy cycles.
- DIV A=0xFFFFFFF9 (-7) B=2:
  - 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=7 B=2: lo=3, hi=1.
- Sequence MTHI A=0x12345678 -> hi=0x12345678 next cycle, busy stays 0.
  - Then DIV A=9 B=0: 10 busy cycles, done pulses, hi=0x12345678, lo unchanged.
- MULT started, reset pulsed asynchronously mid-cycle during busy cycle 3:
  - busy, done, hi, lo go to 0 immediately, before the next edge.
  - No commit afterwards.
  - A new MULTU after reset completes correctly.
- During busy, assert start with MTLO A=0xDEADBEEF: lo unaffected.
  - On the done cycle, start DIVU A=100 B=7: busy next cycle.
  - After 10 cycles: lo=14, hi=2.
